// File: rtl/vram_write_arbiter_if.sv
// Write-request and VRAM write-port bundle for vram_write_arbiter.
// The master side is the pair of writers and the slave side is the arbiter.
interface vram_write_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              req1_en;
  logic              vram_even_we;
  logic [ADDR_W-2:0] vram_even_addr;
  logic [DATA_W-1:0] vram_even_d;
  logic              vram_odd_we;
  logic [ADDR_W-2:0] vram_odd_addr;
  logic [DATA_W-1:0] vram_odd_d;
  logic [CNT_W-1:0]  conflict_count;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, req1_en,
    input  req0_ready, req1_ready,
    input  vram_even_we, vram_even_addr, vram_even_d,
    input  vram_odd_we, vram_odd_addr, vram_odd_d, conflict_count
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data, req1_en,
    output req0_ready, req1_ready,
    output vram_even_we, vram_even_addr, vram_even_d,
    output vram_odd_we, vram_odd_addr, vram_odd_d, conflict_count
  );
endinterface

// File: rtl/vram_write_arbiter.sv
// Two-writer arbiter for the even/odd VRAM write ports: parallel issue on
// different banks, round-robin on same-bank collisions, one-cycle write latency.
module vram_write_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vram_write_arbiter_if.slave   bus
);
  localparam int unsigned BANK_AW = ADDR_W - 1;

  logic               elig0_c, elig1_c, conflict_c, grant0_c, grant1_c;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               even_we_q, even_we_d, odd_we_q, odd_we_d;
  logic [BANK_AW-1:0] even_addr_q, even_addr_d, odd_addr_q, odd_addr_d;
  logic [DATA_W-1:0]  even_data_q, even_data_d, odd_data_q, odd_data_d;

  // Grant decision; rr_q set means the secondary writer wins the next collision.
  always_comb begin
    elig0_c    = bus.req0_valid;
    elig1_c    = bus.req1_valid && bus.req1_en;
    conflict_c = elig0_c && elig1_c && (bus.req0_addr[0] == bus.req1_addr[0]);
    grant0_c   = rst_n && elig0_c && !(conflict_c && rr_q);
    grant1_c   = rst_n && elig1_c && !(conflict_c && !rr_q);
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;

  // Next-state: idle banks keep addr/data so the buses do not toggle.
  always_comb begin
    even_we_d   = 1'b0;
    even_addr_d = even_addr_q;
    even_data_d = even_data_q;
    odd_we_d    = 1'b0;
    odd_addr_d  = odd_addr_q;
    odd_data_d  = odd_data_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;

    if (grant0_c) begin
      if (bus.req0_addr[0]) begin
        odd_we_d   = 1'b1;
        odd_addr_d = bus.req0_addr[ADDR_W-1:1];
        odd_data_d = bus.req0_data;
      end else begin
        even_we_d   = 1'b1;
        even_addr_d = bus.req0_addr[ADDR_W-1:1];
        even_data_d = bus.req0_data;
      end
    end

    // Never lands on the same bank as grant0_c: a collision grants only one side.
    if (grant1_c) begin
      if (bus.req1_addr[0]) begin
        odd_we_d   = 1'b1;
        odd_addr_d = bus.req1_addr[ADDR_W-1:1];
        odd_data_d = bus.req1_data;
      end else begin
        even_we_d   = 1'b1;
        even_addr_d = bus.req1_addr[ADDR_W-1:1];
        even_data_d = bus.req1_data;
      end
    end

    if (conflict_c) begin
      rr_d = ~rr_q;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      even_we_q   <= 1'b0;
      even_addr_q <= '0;
      even_data_q <= '0;
      odd_we_q    <= 1'b0;
      odd_addr_q  <= '0;
      odd_data_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      even_we_q   <= even_we_d;
      even_addr_q <= even_addr_d;
      even_data_q <= even_data_d;
      odd_we_q    <= odd_we_d;
      odd_addr_q  <= odd_addr_d;
      odd_data_q  <= odd_data_d;
    end
  end

  assign bus.vram_even_we   = even_we_q;
  assign bus.vram_even_addr = even_addr_q;
  assign bus.vram_even_d    = even_data_q;
  assign bus.vram_odd_we    = odd_we_q;
  assign bus.vram_odd_addr  = odd_addr_q;
  assign bus.vram_odd_d     = odd_data_q;
  assign bus.conflict_count = cnt_q;
endmodule
